// File: rtl/amba_axi_pkg.sv
// Shared AXI4 types for the memory responder: channel bundles, burst and
// response encodings, responder FSM states and a response-merge helper.
package amba_axi_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 256;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_USER_WIDTH = 1;
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
   // Shift from a byte address to a word address.
   localparam int AXI_WORD_SHIFT = $clog2(AXI_DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi_burst_t;

   // Encoding order makes "worst response" a plain numeric maximum.
   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } axi_slv_wr_st_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } axi_slv_rd_st_t;

   // Initiator-driven signals.
   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   awid;
      logic [AXI_ADDR_WIDTH-1:0] awaddr;
      logic [7:0]                awlen;
      logic [2:0]                awsize;
      logic [1:0]                awburst;
      logic                      awvalid;
      logic [AXI_DATA_WIDTH-1:0] wdata;
      logic [AXI_STRB_WIDTH-1:0] wstrb;
      logic                      wlast;
      logic                      wvalid;
      logic                      bready;
      logic [AXI_ID_WIDTH-1:0]   arid;
      logic [AXI_ADDR_WIDTH-1:0] araddr;
      logic [7:0]                arlen;
      logic [2:0]                arsize;
      logic [1:0]                arburst;
      logic                      arvalid;
      logic                      rready;
   } s_axi_mosi_t;

   // Responder-driven signals.
   typedef struct packed {
      logic                      awready;
      logic                      wready;
      logic [AXI_ID_WIDTH-1:0]   bid;
      logic [1:0]                bresp;
      logic [AXI_USER_WIDTH-1:0] buser;
      logic                      bvalid;
      logic                      arready;
      logic [AXI_ID_WIDTH-1:0]   rid;
      logic [AXI_DATA_WIDTH-1:0] rdata;
      logic [1:0]                rresp;
      logic                      rlast;
      logic [AXI_USER_WIDTH-1:0] ruser;
      logic                      rvalid;
   } s_axi_miso_t;

   // Merge two responses keeping the more severe one.
   function automatic axi_resp_t axi_resp_worst(input axi_resp_t a, input axi_resp_t b);
      if (a > b) return a;
      return b;
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
   import amba_axi_pkg::*;
(
   input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]                i_len,
   input  logic [2:0]                i_size,
   input  logic [1:0]                i_burst,
   output logic [AXI_ADDR_WIDTH-1:0] o_next_addr
);

   logic [AXI_ADDR_WIDTH-1:0] w_step;
   logic [AXI_ADDR_WIDTH-1:0] w_mask;
   logic [AXI_ADDR_WIDTH-1:0] w_incr;

   // Select the next address by burst type; WRAP keeps the upper bits of the container.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_next_addr = i_addr;
      w_step      = AXI_ADDR_WIDTH'(1) << i_size;
      w_mask      = ((AXI_ADDR_WIDTH'(i_len) + AXI_ADDR_WIDTH'(1)) << i_size) - AXI_ADDR_WIDTH'(1);
      w_incr      = i_addr + w_step;
      case (axi_burst_t'(i_burst))
         AXI_BURST_INCR: o_next_addr = w_incr;
         AXI_BURST_WRAP: o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
         default:        o_next_addr = i_addr;
      endcase
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a flop-array memory. Independent read and write
// FSMs, one transaction each; all responder outputs are registered.
module axi_mem_slave
   import amba_axi_pkg::*;
#(
   parameter int                        MEM_WORDS = 1024,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic        aclk,
   input  logic        arst,
   input  s_axi_mosi_t axi_mosi_i,
   output s_axi_miso_t axi_miso_o
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   typedef logic [IDX_W-1:0]          idx_t;
   typedef logic [AXI_ADDR_WIDTH:0]   addr_ext_t;
   localparam addr_ext_t MEM_BYTES = addr_ext_t'(MEM_WORDS) << AXI_WORD_SHIFT;

   // Extra top bit catches addresses below the base: the borrow makes the offset huge.
   function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
      return ({1'b0, a} - {1'b0, BASE_ADDR}) < MEM_BYTES;
   endfunction

   function automatic idx_t word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
      return idx_t'((a - BASE_ADDR) >> AXI_WORD_SHIFT);
   endfunction

   // Response of a single beat; only OKAY beats touch memory.
   function automatic axi_resp_t beat_resp(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [1:0] burst);
      if (axi_burst_t'(burst) == AXI_BURST_RSVD) return AXI_RESP_SLVERR;
      if (!in_range(a))                          return AXI_RESP_DECERR;
      return AXI_RESP_OKAY;
   endfunction

   logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   // ---------------- write path ----------------
   axi_slv_wr_st_t            r_wr_state, w_wr_next;
   logic                      r_awready, r_wready, r_bvalid;
   logic                      w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
   logic [AXI_ID_WIDTH-1:0]   r_awid;
   logic [AXI_ADDR_WIDTH-1:0] r_waddr, w_wr_next_addr;
   logic [7:0]                r_awlen, r_wbeat;
   logic [2:0]                r_awsize;
   logic [1:0]                r_awburst;
   axi_resp_t                 r_bresp, w_w_resp, w_w_beat_resp;
   logic                      w_aw_hs, w_w_hs, w_b_hs, w_w_last_beat, w_mem_we;

   assign w_aw_hs       = axi_mosi_i.awvalid & r_awready;
   assign w_w_hs        = axi_mosi_i.wvalid & r_wready;
   assign w_b_hs        = r_bvalid & axi_mosi_i.bready;
   assign w_w_last_beat = (r_wbeat == r_awlen);
   assign w_w_resp      = beat_resp(r_waddr, r_awburst);
   assign w_w_beat_resp = axi_resp_worst(w_w_resp,
                             (axi_mosi_i.wlast != w_w_last_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
   assign w_mem_we      = w_w_hs && (w_w_resp == AXI_RESP_OKAY);

   axi_burst_addr_gen u_wr_addr_gen (
      .i_addr      (r_waddr),
      .i_len       (r_awlen),
      .i_size      (r_awsize),
      .i_burst     (r_awburst),
      .o_next_addr (w_wr_next_addr)
   );

   // Write FSM next state and the ready/valid values to register alongside it.
   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         WR_IDLE: if (w_aw_hs)                  w_wr_next = WR_DATA;
         WR_DATA: if (w_w_hs && w_w_last_beat)  w_wr_next = WR_RESP;
         WR_RESP: if (w_b_hs)                   w_wr_next = WR_IDLE;
         default:                               w_wr_next = WR_IDLE;
      endcase
      w_awready_nxt = (w_wr_next == WR_IDLE);
      w_wready_nxt  = (w_wr_next == WR_DATA);
      w_bvalid_nxt  = (w_wr_next == WR_RESP);
   end

   // Write FSM state and handshake outputs; all low in reset so awready rises one edge after release.
   always_ff @(posedge aclk or posedge arst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (arst) begin
         r_wr_state <= WR_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         r_awready  <= w_awready_nxt;
         r_wready   <= w_wready_nxt;
         r_bvalid   <= w_bvalid_nxt;
      end
   end

   // Write request capture, beat address/count and accumulated worst response.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_awid    <= '0;
         r_waddr   <= '0;
         r_awlen   <= '0;
         r_awsize  <= '0;
         r_awburst <= '0;
         r_wbeat   <= '0;
         r_bresp   <= AXI_RESP_OKAY;
      end else if (w_aw_hs) begin
         r_awid    <= axi_mosi_i.awid;
         r_waddr   <= axi_mosi_i.awaddr;
         r_awlen   <= axi_mosi_i.awlen;
         r_awsize  <= axi_mosi_i.awsize;
         r_awburst <= axi_mosi_i.awburst;
         r_wbeat   <= '0;
         r_bresp   <= AXI_RESP_OKAY;
      end else if (w_w_hs) begin
         r_waddr   <= w_wr_next_addr;
         r_wbeat   <= r_wbeat + 8'd1;
         r_bresp   <= axi_resp_worst(r_bresp, w_w_beat_resp);
      end
   end

   // Byte-enabled memory write port.
   always_ff @(posedge aclk) begin
      // NOTE: the storage array has no reset; contents survive arst, only control state is cleared.
      if (w_mem_we) begin
         for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
            if (axi_mosi_i.wstrb[b]) r_mem[word_idx(r_waddr)][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   axi_slv_rd_st_t            r_rd_state, w_rd_next;
   logic                      r_arready, r_rvalid, w_arready_nxt, w_rvalid_nxt;
   logic [AXI_ID_WIDTH-1:0]   r_rid;
   logic [AXI_DATA_WIDTH-1:0] r_rdata, w_ld_data;
   axi_resp_t                 r_rresp, w_ld_resp;
   logic                      r_rlast;
   logic [AXI_ADDR_WIDTH-1:0] r_raddr, w_rd_next_addr, w_ld_addr;
   logic [7:0]                r_arlen, r_rbeat;
   logic [2:0]                r_arsize;
   logic [1:0]                r_arburst, w_ld_burst;
   logic                      w_ar_hs, w_r_hs;

   assign w_ar_hs    = axi_mosi_i.arvalid & r_arready;
   assign w_r_hs     = r_rvalid & axi_mosi_i.rready;
   assign w_ld_addr  = w_ar_hs ? axi_mosi_i.araddr  : w_rd_next_addr;
   assign w_ld_burst = w_ar_hs ? axi_mosi_i.arburst : r_arburst;
   assign w_ld_resp  = beat_resp(w_ld_addr, w_ld_burst);
   assign w_ld_data  = (w_ld_resp == AXI_RESP_OKAY) ? r_mem[word_idx(w_ld_addr)] : '0;

   axi_burst_addr_gen u_rd_addr_gen (
      .i_addr      (r_raddr),
      .i_len       (r_arlen),
      .i_size      (r_arsize),
      .i_burst     (r_arburst),
      .o_next_addr (w_rd_next_addr)
   );

   // Read FSM next state and the ready/valid values to register alongside it.
   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         RD_IDLE: if (w_ar_hs)            w_rd_next = RD_DATA;
         RD_DATA: if (w_r_hs && r_rlast)  w_rd_next = RD_IDLE;
         default:                         w_rd_next = RD_IDLE;
      endcase
      w_arready_nxt = (w_rd_next == RD_IDLE);
      w_rvalid_nxt  = (w_rd_next == RD_DATA);
   end

   // Read FSM state and handshake outputs.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_rd_state <= RD_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
      end else begin
         r_rd_state <= w_rd_next;
         r_arready  <= w_arready_nxt;
         r_rvalid   <= w_rvalid_nxt;
      end
   end

   // R output register: loads beat 0 on AR, then the next beat on each accepted beat; holds otherwise.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= AXI_RESP_OKAY;
         r_rlast   <= 1'b0;
         r_raddr   <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_rbeat   <= '0;
      end else if (w_ar_hs) begin
         r_rid     <= axi_mosi_i.arid;
         r_raddr   <= axi_mosi_i.araddr;
         r_arlen   <= axi_mosi_i.arlen;
         r_arsize  <= axi_mosi_i.arsize;
         r_arburst <= axi_mosi_i.arburst;
         r_rbeat   <= '0;
         r_rdata   <= w_ld_data;
         r_rresp   <= w_ld_resp;
         r_rlast   <= (axi_mosi_i.arlen == 8'd0);
      end else if (w_r_hs && !r_rlast) begin
         r_raddr   <= w_rd_next_addr;
         r_rbeat   <= r_rbeat + 8'd1;
         r_rdata   <= w_ld_data;
         r_rresp   <= w_ld_resp;
         r_rlast   <= ((r_rbeat + 8'd1) == r_arlen);
      end
   end

   // Pack registered state onto the responder bundle; user and unused fields stay zero.
   always_comb begin
      axi_miso_o         = '0;
      axi_miso_o.awready = r_awready;
      axi_miso_o.wready  = r_wready;
      axi_miso_o.bid     = r_awid;
      axi_miso_o.bresp   = r_bresp;
      axi_miso_o.bvalid  = r_bvalid;
      axi_miso_o.arready = r_arready;
      axi_miso_o.rid     = r_rid;
      axi_miso_o.rdata   = r_rdata;
      axi_miso_o.rresp   = r_rresp;
      axi_miso_o.rlast   = r_rlast;
      axi_miso_o.rvalid  = r_rvalid;
   end

endmodule
